// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The receive FSM states and the frame-size limits live here.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int MIN_BIT_PERIOD = 10;
    localparam int MAX_DATA_SIZE  = 8;

    // Out-of-range frame sizes fall back to a full byte.
    function automatic logic [3:0] eff_data_size(input logic [3:0] size);
        if (size >= 4'd5 && size <= 4'(MAX_DATA_SIZE)) begin
            return size;
        end
        return 4'(MAX_DATA_SIZE);
    endfunction

endpackage

// File: rtl/uart_rx_timer.sv
// Per-bit timer for the UART receiver: counts 0..period-1 and flags the mid-bit
// sample point and the last cycle of the bit.
module uart_rx_timer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear_i,
    input  logic [13:0] period_i,
    output logic        mid_o,
    output logic        end_o
);

    logic [13:0] count_q;
    logic [13:0] count_d;

    assign mid_o = (count_q == (period_i >> 1));
    assign end_o = (count_q == (period_i - 14'd1));

    always_comb begin
        count_d = count_q + 14'd1;
        if (clear_i || end_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises the serial line, deframes start/data/stop bits
// and holds the last good byte together with ready, overrun and framing status.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_BIT_PERIOD = uart_pkg::MIN_BIT_PERIOD
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        serial_in,
    input  logic [3:0]  data_size,
    input  logic [13:0] bit_period,
    input  logic        data_read,
    output logic [7:0]  rx_data,
    output logic        data_ready,
    output logic        overrun_error,
    output logic        framing_error
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   s;

    rx_state_t   state_q, state_d;
    logic [13:0] period_q, period_d;
    logic [3:0]  size_q, size_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        stop_seen_q, stop_seen_d;
    logic        stop_bit_q, stop_bit_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        ready_q, ready_d;
    logic        overrun_q, overrun_d;
    logic        framing_q, framing_d;

    logic        timer_clear;
    logic        tmr_mid;
    logic        tmr_end;

    assign s = sync_q[SYNC_STAGES-1];

    // The line idles high, so the synchroniser resets to ones to avoid a phantom start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q   <= '1;
            s_prev_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], serial_in};
            s_prev_q <= s;
        end
    end

    uart_rx_timer u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear_i  (timer_clear),
        .period_i (period_q),
        .mid_o    (tmr_mid),
        .end_o    (tmr_end)
    );

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        size_d      = size_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        stop_seen_d = stop_seen_q;
        stop_bit_d  = stop_bit_q;
        rx_data_d   = rx_data_q;
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        framing_d   = framing_q;
        timer_clear = 1'b0;

        if (data_read && ready_q) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                stop_seen_d = 1'b0;
                if (s_prev_q && !s) begin
                    period_d = (bit_period < 14'(MIN_BIT_PERIOD)) ? 14'(MIN_BIT_PERIOD) : bit_period;
                    size_d   = eff_data_size(data_size);
                    bitcnt_d = '0;
                    shift_d  = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (tmr_mid && s) begin
                    state_d = IDLE;
                end else if (tmr_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tmr_mid) begin
                    shift_d[bitcnt_q[2:0]] = s;
                    bitcnt_d = bitcnt_q + 4'd1;
                end
                if (tmr_end && bitcnt_q == size_q) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Commit one cycle after the stop sample and leave early so the next start edge resyncs.
                if (stop_seen_q) begin
                    state_d = IDLE;
                    if (stop_bit_q) begin
                        rx_data_d = shift_q;
                        ready_d   = 1'b1;
                        framing_d = 1'b0;
                        if (ready_q && !data_read) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        framing_d = 1'b1;
                    end
                end else if (tmr_mid) begin
                    stop_seen_d = 1'b1;
                    stop_bit_d  = s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            period_q    <= 14'(MIN_BIT_PERIOD);
            size_q      <= 4'(MAX_DATA_SIZE);
            bitcnt_q    <= '0;
            shift_q     <= '0;
            stop_seen_q <= 1'b0;
            stop_bit_q  <= 1'b0;
            rx_data_q   <= '0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            framing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            size_q      <= size_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            stop_seen_q <= stop_seen_d;
            stop_bit_q  <= stop_bit_d;
            rx_data_q   <= rx_data_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            framing_q   <= framing_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: drives UART frames and compares the status
// registers against a frame-level reference model.
module tb_uart_rx_core;

    logic        clk;
    logic        n_rst;
    logic        serial_in;
    logic [3:0]  data_size;
    logic [13:0] bit_period;
    logic        data_read;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        overrun_error;
    logic        framing_error;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] mRx;
    logic       mReady;
    logic       mOverrun;
    logic       mFraming;

    uart_rx_core dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_size     (data_size),
        .bit_period    (bit_period),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int effSize(input logic [3:0] sz);
        return (sz >= 5 && sz <= 8) ? int'(sz) : 8;
    endfunction

    function automatic int effCycles(input logic [13:0] bp);
        return (bp < 10) ? 10 : int'(bp);
    endfunction

    // Drives a whole frame with the configured timing, then idles, then updates the model.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        int nBits;
        int cyc;
        logic [7:0] mask;
        nBits = effSize(data_size);
        cyc   = effCycles(bit_period);
        mask  = 8'((16'd1 << nBits) - 16'd1);
        serial_in = 1'b0;
        repeat (cyc) @(negedge clk);
        for (int i = 0; i < nBits; i++) begin
            serial_in = data[i];
            repeat (cyc) @(negedge clk);
        end
        serial_in = stopBit;
        repeat (cyc) @(negedge clk);
        serial_in = 1'b1;
        repeat (cyc) @(negedge clk);
        if (stopBit) begin
            if (mReady) mOverrun = 1'b1;
            mRx      = data & mask;
            mReady   = 1'b1;
            mFraming = 1'b0;
        end else begin
            mFraming = 1'b1;
        end
    endtask

    task automatic pulseRead();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        @(negedge clk);
        if (mReady) begin
            mReady   = 1'b0;
            mOverrun = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== 11'd0)
            $display("[TB] FAIL reset_state: got %h/%b%b%b, want 00/000", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        bit_period = 14'd10;
        data_size  = 4'd8;
        sendFrame(8'hA5, 1'b1);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {8'hA5, 3'b100})
            $display("[TB] FAIL basic_a5: got %h/%b%b%b, want a5/100", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
        pulseRead();
    endtask

    task automatic test_sizes();
        logic [4:0]  sizes [2] = '{5'd5, 5'd7};
        logic [7:0]  datas [2] = '{8'h1B, 8'h55};
        for (int i = 0; i < 2; i++) begin
            data_size = sizes[i][3:0];
            sendFrame(datas[i], 1'b1);
            checkCount++;
            if ({rx_data, data_ready, overrun_error, framing_error} !== {mRx, mReady, mOverrun, mFraming})
                $display("[TB] FAIL size_%0d: got %h/%b%b%b, want %h/%b%b%b", sizes[i], rx_data, data_ready,
                         overrun_error, framing_error, mRx, mReady, mOverrun, mFraming);
            else passCount++;
            pulseRead();
        end
        data_size = 4'd8;
    endtask

    task automatic test_overrun();
        sendFrame(8'h3C, 1'b1);
        sendFrame(8'hC3, 1'b1);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {8'hC3, 3'b110})
            $display("[TB] FAIL overrun_set: got %h/%b%b%b, want c3/110", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
        pulseRead();
        checkCount++;
        if ({data_ready, overrun_error} !== 2'b00)
            $display("[TB] FAIL overrun_clear: got %b%b, want 00", data_ready, overrun_error);
        else passCount++;
    endtask

    task automatic test_framing();
        sendFrame(8'h81, 1'b0);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {8'hC3, 3'b001})
            $display("[TB] FAIL framing_set: got %h/%b%b%b, want c3/001", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
        sendFrame(8'h42, 1'b1);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {8'h42, 3'b100})
            $display("[TB] FAIL framing_clear: got %h/%b%b%b, want 42/100", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
    endtask

    task automatic test_glitch();
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (30) @(negedge clk);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {mRx, mReady, mOverrun, mFraming})
            $display("[TB] FAIL glitch: got %h/%b%b%b, want %h/%b%b%b", rx_data, data_ready, overrun_error,
                     framing_error, mRx, mReady, mOverrun, mFraming);
        else passCount++;
        pulseRead();
        sendFrame(8'h96, 1'b1);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {8'h96, 3'b100})
            $display("[TB] FAIL after_glitch: got %h/%b%b%b, want 96/100", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
        pulseRead();
    endtask

    task automatic test_min_period();
        bit_period = 14'd4;
        sendFrame(8'h6E, 1'b1);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {8'h6E, 3'b100})
            $display("[TB] FAIL min_period: got %h/%b%b%b, want 6e/100", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
        bit_period = 14'd10;
    endtask

    task automatic test_random();
        logic [7:0] data;
        logic       stopBit;
        for (int i = 0; i < 10; i++) begin
            data       = 8'($urandom);
            data_size  = 4'($urandom_range(0, 15));
            bit_period = 14'($urandom_range(0, 24));
            stopBit    = ($urandom_range(0, 3) != 0);
            sendFrame(data, stopBit);
            checkCount++;
            if ({rx_data, data_ready, overrun_error, framing_error} !== {mRx, mReady, mOverrun, mFraming})
                $display("[TB] FAIL random_%0d: got %h/%b%b%b, want %h/%b%b%b (size=%0d bp=%0d)", i, rx_data,
                         data_ready, overrun_error, framing_error, mRx, mReady, mOverrun, mFraming,
                         data_size, bit_period);
            else passCount++;
            if ($urandom_range(0, 1) == 1) pulseRead();
        end
        data_size  = 4'd8;
        bit_period = 14'd10;
    endtask

    task automatic test_reset_mid_frame();
        sendFrame(8'hFF, 1'b1);
        serial_in = 1'b0;
        repeat (10) @(negedge clk);
        serial_in = 1'b1;
        repeat (15) @(negedge clk);
        n_rst = 1'b0;
        #1;
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== 11'd0)
            $display("[TB] FAIL reset_mid_data: got %h/%b%b%b, want 00/000", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
        mRx = '0; mReady = 1'b0; mOverrun = 1'b0; mFraming = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (30) @(negedge clk);
        sendFrame(8'h5A, 1'b1);
        checkCount++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {8'h5A, 3'b100})
            $display("[TB] FAIL after_reset: got %h/%b%b%b, want 5a/100", rx_data, data_ready, overrun_error, framing_error);
        else passCount++;
    endtask

    initial begin
        n_rst      = 1'b0;
        serial_in  = 1'b1;
        data_size  = 4'd8;
        bit_period = 14'd10;
        data_read  = 1'b0;
        mRx = '0; mReady = 1'b0; mOverrun = 1'b0; mFraming = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_sizes();
        test_overrun();
        test_framing();
        test_glitch();
        test_min_period();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
